// File: rtl/display_timing.sv
// display_timing -- raster timing generator for a single pixel clock.
//
// Walks a signed raster position (o_x, o_y) through blanking and active
// regions and decodes sync, data-enable and start-of-line/frame strobes from
// that same position, so every output describes one raster point per clock.
// Blanking positions are negative; the active area starts at (0, 0).
//
// Parameters:
//   H_RES/H_FP/H_SYNC/H_BP  active pixels, front porch, sync width, back porch
//   V_RES/V_FP/V_SYNC/V_BP  same, in lines
//   H_POL/V_POL             active level of o_hsync / o_vsync
//
// Ports:
//   i_clk    pixel clock, all logic on its rising edge
//   i_rst_n  synchronous active-low reset
//   o_hsync  horizontal sync
//   o_vsync  vertical sync
//   o_de     data enable, high in the active area
//   o_frame  one-clock pulse at the first position of each frame
//   o_line   one-clock pulse at the first position of each line
//   o_x/o_y  signed 16-bit raster position
//
// Build option: define DISPLAY_TIMING_OUT_REG_EN to add one extra register
// stage on every output (one more clock of latency, reset values unchanged).
module display_timing #(
  parameter int   H_RES  = 640,
  parameter int   H_FP   = 16,
  parameter int   H_SYNC = 96,
  parameter int   H_BP   = 48,
  parameter int   V_RES  = 480,
  parameter int   V_FP   = 10,
  parameter int   V_SYNC = 2,
  parameter int   V_BP   = 33,
  parameter logic H_POL  = 1'b0,
  parameter logic V_POL  = 1'b0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic               o_de,
  output logic               o_frame,
  output logic               o_line,
  output logic signed [15:0] o_x,
  output logic signed [15:0] o_y
);

  localparam logic signed [15:0] H_STA  = 16'(-(H_FP + H_SYNC + H_BP));
  localparam logic signed [15:0] H_END  = 16'(H_RES - 1);
  localparam logic signed [15:0] V_STA  = 16'(-(V_FP + V_SYNC + V_BP));
  localparam logic signed [15:0] V_END  = 16'(V_RES - 1);
  // Sync windows expressed relative to the active origin: the sync pulse
  // ends exactly one back porch before position 0.
  localparam logic signed [15:0] HS_STA = 16'(-(H_SYNC + H_BP));
  localparam logic signed [15:0] HS_END = 16'(-H_BP - 1);
  localparam logic signed [15:0] VS_STA = 16'(-(V_SYNC + V_BP));
  localparam logic signed [15:0] VS_END = 16'(-V_BP - 1);

  logic signed [15:0] x_nxt;
  logic signed [15:0] y_nxt;

  logic signed [15:0] x_p0;
  logic signed [15:0] y_p0;
  logic               vld_p0;
  logic               hs_p0;
  logic               vs_p0;
  logic               de_p0;
  logic               frame_p0;
  logic               line_p0;

  // vld_p0 is low for the first edge after reset so that edge presents the
  // frame origin itself instead of stepping past it.
  always_comb begin
    x_nxt = H_STA;
    y_nxt = V_STA;
    if (vld_p0) begin
      if (x_p0 == H_END) begin
        x_nxt = H_STA;
        y_nxt = (y_p0 == V_END) ? V_STA : y_p0 + 16'sd1;
      end else begin
        x_nxt = x_p0 + 16'sd1;
        y_nxt = y_p0;
      end
    end
  end

  // Stage p0: position and everything decoded from it, registered together.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      vld_p0   <= 1'b0;
      x_p0     <= H_STA;
      y_p0     <= V_STA;
      hs_p0    <= ~H_POL;
      vs_p0    <= ~V_POL;
      de_p0    <= 1'b0;
      frame_p0 <= 1'b0;
      line_p0  <= 1'b0;
    end else begin
      vld_p0   <= 1'b1;
      x_p0     <= x_nxt;
      y_p0     <= y_nxt;
      hs_p0    <= ((x_nxt >= HS_STA) && (x_nxt <= HS_END)) ? H_POL : ~H_POL;
      vs_p0    <= ((y_nxt >= VS_STA) && (y_nxt <= VS_END)) ? V_POL : ~V_POL;
      de_p0    <= (x_nxt >= 16'sd0) && (y_nxt >= 16'sd0);
      frame_p0 <= (x_nxt == H_STA) && (y_nxt == V_STA);
      line_p0  <= (x_nxt == H_STA);
    end
  end

`ifdef DISPLAY_TIMING_OUT_REG_EN
  logic signed [15:0] x_p1;
  logic signed [15:0] y_p1;
  logic               hs_p1;
  logic               vs_p1;
  logic               de_p1;
  logic               frame_p1;
  logic               line_p1;

  // Stage p1: plain delay of every p0 output, reset to the same values.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      x_p1     <= H_STA;
      y_p1     <= V_STA;
      hs_p1    <= ~H_POL;
      vs_p1    <= ~V_POL;
      de_p1    <= 1'b0;
      frame_p1 <= 1'b0;
      line_p1  <= 1'b0;
    end else begin
      x_p1     <= x_p0;
      y_p1     <= y_p0;
      hs_p1    <= hs_p0;
      vs_p1    <= vs_p0;
      de_p1    <= de_p0;
      frame_p1 <= frame_p0;
      line_p1  <= line_p0;
    end
  end

  assign o_x     = x_p1;
  assign o_y     = y_p1;
  assign o_hsync = hs_p1;
  assign o_vsync = vs_p1;
  assign o_de    = de_p1;
  assign o_frame = frame_p1;
  assign o_line  = line_p1;
`else
  assign o_x     = x_p0;
  assign o_y     = y_p0;
  assign o_hsync = hs_p0;
  assign o_vsync = vs_p0;
  assign o_de    = de_p0;
  assign o_frame = frame_p0;
  assign o_line  = line_p0;
`endif

endmodule

// File: tb/tb_display_timing.sv
// Testbench for display_timing: a small-raster instance (fast full frames)
// and a default-parameter instance, both compared every clock against a
// position-index model, plus directed table vectors and reset sequences.
module tb_display_timing;

`ifdef DISPLAY_TIMING_OUT_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  // Small raster: H_STA=-9, line 25 clocks; V_STA=-6, 12 lines; frame 300.
  localparam int S_HRES = 16, S_HFP = 2, S_HSY = 3, S_HBP = 4;
  localparam int S_VRES = 6,  S_VFP = 1, S_VSY = 2, S_VBP = 3;

  typedef struct packed {
    int   x;
    int   y;
    logic fr;
    logic ln;
    logic de;
    logic hs;
    logic vs;
  } outs_t;

  typedef struct {
    int    n;
    outs_t e;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic               s_hs, s_vs, s_de, s_fr, s_ln;
  logic signed [15:0] s_x, s_y;
  logic               d_hs, d_vs, d_de, d_fr, d_ln;
  logic signed [15:0] d_x, d_y;

  int checks = 0;
  int failures = 0;
  int k = 0;

  always #5 clk = ~clk;

  display_timing #(
    .H_RES(S_HRES), .H_FP(S_HFP), .H_SYNC(S_HSY), .H_BP(S_HBP),
    .V_RES(S_VRES), .V_FP(S_VFP), .V_SYNC(S_VSY), .V_BP(S_VBP),
    .H_POL(1'b0), .V_POL(1'b1)
  ) dut_s (
    .i_clk(clk), .i_rst_n(rst_n), .o_hsync(s_hs), .o_vsync(s_vs),
    .o_de(s_de), .o_frame(s_fr), .o_line(s_ln), .o_x(s_x), .o_y(s_y)
  );

  display_timing dut_d (
    .i_clk(clk), .i_rst_n(rst_n), .o_hsync(d_hs), .o_vsync(d_vs),
    .o_de(d_de), .o_frame(d_fr), .o_line(d_ln), .o_x(d_x), .o_y(d_y)
  );

  function automatic outs_t mk(int x, int y, logic fr, logic ln, logic de, logic hs, logic vs);
    outs_t o;
    o.x = x; o.y = y; o.fr = fr; o.ln = ln; o.de = de; o.hs = hs; o.vs = vs;
    return o;
  endfunction

  function automatic vec_t mkv(int n, outs_t e);
    vec_t v;
    v.n = n; v.e = e;
    return v;
  endfunction

  // k = rising edges seen with reset released since the last reset edge.
  // Position index n counts raster points from the frame origin.
  function automatic outs_t model(int kk, int hres, int hfp, int hsy, int hbp,
                                  int vres, int vfp, int vsy, int vbp,
                                  logic hpol, logic vpol);
    outs_t e;
    int hsta, vsta, ht, vt, n;
    hsta = -(hfp + hsy + hbp);
    vsta = -(vfp + vsy + vbp);
    ht = hres - hsta;
    vt = vres - vsta;
    if (kk <= LAT) begin
      e = mk(hsta, vsta, 1'b0, 1'b0, 1'b0, ~hpol, ~vpol);
    end else begin
      n = kk - 1 - LAT;
      e.x  = hsta + n % ht;
      e.y  = vsta + (n / ht) % vt;
      e.ln = (n % ht) == 0;
      e.fr = (n % (ht * vt)) == 0;
      e.de = (e.x >= 0) && (e.y >= 0);
      e.hs = (e.x >= hsta + hfp && e.x <= hsta + hfp + hsy - 1) ? hpol : ~hpol;
      e.vs = (e.y >= vsta + vfp && e.y <= vsta + vfp + vsy - 1) ? vpol : ~vpol;
    end
    return e;
  endfunction

  function automatic outs_t act_s();
    return mk(int'(s_x), int'(s_y), s_fr, s_ln, s_de, s_hs, s_vs);
  endfunction

  function automatic outs_t act_d();
    return mk(int'(d_x), int'(d_y), d_fr, d_ln, d_de, d_hs, d_vs);
  endfunction

  task automatic chk_out(string name, outs_t e, outs_t a);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s k=%0d: got x=%0d y=%0d fr=%b ln=%b de=%b hs=%b vs=%b, want x=%0d y=%0d fr=%b ln=%b de=%b hs=%b vs=%b",
               name, k, a.x, a.y, a.fr, a.ln, a.de, a.hs, a.vs,
               e.x, e.y, e.fr, e.ln, e.de, e.hs, e.vs);
    end
  endtask

  task automatic chk_int(string name, int a, int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", name, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) k = 0;
    else k++;
    #1;
    chk_out("model_small", model(k, S_HRES, S_HFP, S_HSY, S_HBP, S_VRES, S_VFP, S_VSY, S_VBP, 1'b0, 1'b1), act_s());
    chk_out("model_default", model(k, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0), act_d());
  endtask

  localparam int NT = 14;
  vec_t tbl[NT];

  initial begin
    int ti, n, hs_low, first_low_x, de_d_cnt, fr_cnt, ln_cnt, de_s_cnt, last_fk, found, rst_left;

    // Hand-derived points of the small raster (H_POL=0, V_POL=1).
    tbl[0]  = mkv(0,   mk(-9, -6, 1, 1, 0, 1, 0));
    tbl[1]  = mkv(2,   mk(-7, -6, 0, 0, 0, 0, 0));
    tbl[2]  = mkv(4,   mk(-5, -6, 0, 0, 0, 0, 0));
    tbl[3]  = mkv(5,   mk(-4, -6, 0, 0, 0, 1, 0));
    tbl[4]  = mkv(9,   mk(0,  -6, 0, 0, 0, 1, 0));
    tbl[5]  = mkv(24,  mk(15, -6, 0, 0, 0, 1, 0));
    tbl[6]  = mkv(25,  mk(-9, -5, 0, 1, 0, 1, 1));
    tbl[7]  = mkv(50,  mk(-9, -4, 0, 1, 0, 1, 1));
    tbl[8]  = mkv(75,  mk(-9, -3, 0, 1, 0, 1, 0));
    tbl[9]  = mkv(159, mk(0,   0, 0, 0, 1, 1, 0));
    tbl[10] = mkv(174, mk(15,  0, 0, 0, 1, 1, 0));
    tbl[11] = mkv(175, mk(-9,  1, 0, 1, 0, 1, 0));
    tbl[12] = mkv(299, mk(15,  5, 0, 0, 1, 1, 0));
    tbl[13] = mkv(300, mk(-9, -6, 1, 1, 0, 1, 0));

    // Reset held: reset values on both instances.
    rst_n = 1'b0;
    repeat (3) step();
    chk_out("reset_small", mk(-9, -6, 0, 0, 0, 1, 0), act_s());
    chk_out("reset_default", mk(-160, -45, 0, 0, 0, 1, 1), act_d());

    rst_n = 1'b1;
    ti = 0; hs_low = 0; first_low_x = 0; de_d_cnt = 0;
    fr_cnt = 0; ln_cnt = 0; de_s_cnt = 0; last_fk = -1;
    while (k < 801 + LAT) begin
      step();
      n = k - 1 - LAT;
      if (n == 0)
        chk_out("default_first", mk(-160, -45, 1, 1, 0, 1, 1), act_d());
      if (ti < NT && n == tbl[ti].n) begin
        chk_out($sformatf("table%0d", ti), tbl[ti].e, act_s());
        ti++;
      end
      if (n >= 0 && n < 800) begin
        if (!d_hs) begin
          if (hs_low == 0) first_low_x = int'(d_x);
          hs_low++;
        end
        if (d_de) de_d_cnt++;
      end
      if (n >= 300 && n < 600) begin
        if (s_fr) fr_cnt++;
        if (s_ln) ln_cnt++;
        if (s_de) de_s_cnt++;
      end
      if (n >= 0 && s_fr) begin
        if (last_fk >= 0) chk_int("frame_period", k - last_fk, 300);
        last_fk = k;
      end
    end
    chk_int("table_applied", ti, NT);
    chk_int("default_hsync_low_clocks", hs_low, 96);
    chk_int("default_hsync_first_x", first_low_x, -144);
    chk_int("default_de_blank_line", de_d_cnt, 0);
    chk_int("frame_pulses", fr_cnt, 1);
    chk_int("line_pulses", ln_cnt, 12);
    chk_int("de_clocks", de_s_cnt, 96);

    // Reset in mid-frame at (10, 2), held for three clocks, then restart.
    found = 0;
    for (int b = 0; b < 400 && found == 0; b++) begin
      if (s_x == 16'sd10 && s_y == 16'sd2) found = 1;
      else step();
    end
    chk_int("reach_mid_frame", found, 1);
    rst_n = 1'b0;
    repeat (3) begin
      step();
      chk_out("mid_reset", mk(-9, -6, 0, 0, 0, 1, 0), act_s());
    end
    rst_n = 1'b1;
    repeat (1 + LAT) step();
    chk_out("restart_small", mk(-9, -6, 1, 1, 0, 1, 0), act_s());
    chk_out("restart_default", mk(-160, -45, 1, 1, 0, 1, 1), act_d());

    // Random reset pulses, checked each clock by the model inside step().
    rst_left = 0;
    for (int i = 0; i < 20000; i++) begin
      if (rst_left == 0 && $urandom_range(0, 599) == 0)
        rst_left = int'($urandom_range(1, 4));
      rst_n = (rst_left == 0);
      if (rst_left > 0) rst_left--;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/display_timing.md
DISPLAY_TIMING -- requirements
Module: display_timing

Interface
REQ-001 SHALL have parameter H_RES, default 640, meaning active pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, meaning horizontal front porch in clocks.
REQ-003 SHALL have parameter H_SYNC, default 96, meaning hsync width in clocks.
REQ-004 SHALL have parameter H_BP, default 48, meaning horizontal back porch in clocks.
REQ-005 SHALL have parameter V_RES, default 480, meaning active lines per frame.
REQ-006 SHALL have parameter V_FP, default 10, meaning vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, meaning vsync width in lines.
REQ-008 SHALL have parameter V_BP, default 33, meaning vertical back porch in lines.
REQ-009 SHALL have parameter H_POL, default 0, meaning hsync active level.
REQ-010 SHALL have parameter V_POL, default 0, meaning vsync active level.
REQ-011 SHALL have port i_clk, input, 1, the pixel clock; one clock, all logic on its rising edge.
REQ-012 SHALL have port i_rst_n, input, 1, reset; synchronous and active-low.
REQ-013 SHALL have port o_hsync, output, 1, horizontal sync.
REQ-014 SHALL have port o_vsync, output, 1, vertical sync.
REQ-015 SHALL have port o_de, output, 1, data enable, high in the active area.
REQ-016 SHALL have port o_frame, output, 1, one-clock pulse at the first position of each frame.
REQ-017 SHALL have port o_line, output, 1, one-clock pulse at the first position of each line.
REQ-018 SHALL have port o_x, output, signed 16, current horizontal position.
REQ-019 SHALL have port o_y, output, signed 16, current vertical position.

Function
REQ-020 SHALL define H_STA = -(H_FP+H_SYNC+H_BP), H_END = H_RES-1, V_STA = -(V_FP+V_SYNC+V_BP), V_END = V_RES-1; defaults give -160, 639, -45, 479.
REQ-021 SHALL advance o_x by 1 per clock from H_STA to H_END, then wrap it to H_STA.
REQ-022 SHALL increment o_y only in the clock where o_x wraps.
REQ-023 SHALL wrap o_y to V_STA when o_x wraps while o_y == V_END.
REQ-024 SHALL assert o_de exactly when o_x >= 0 and o_y >= 0.
REQ-025 SHALL drive o_hsync to H_POL for o_x in [H_STA+H_FP, H_STA+H_FP+H_SYNC-1] (defaults -144..-49), else to ~H_POL.
REQ-026 SHALL drive o_vsync to V_POL for o_y in [V_STA+V_FP, V_STA+V_FP+V_SYNC-1] (defaults -35..-34), for every o_x on those lines, else to ~V_POL.
REQ-027 SHALL assert o_line exactly when o_x == H_STA.
REQ-028 SHALL assert o_frame exactly when o_x == H_STA and o_y == V_STA.
REQ-029 SHALL register all outputs, and all outputs SHALL be mutually aligned: every output describes the same raster position in every clock.
REQ-030 SHALL produce a frame period of (H_RES-H_STA)*(V_RES-V_STA) clocks; with defaults, 800*525 = 420000.
REQ-031 SHALL treat any combination where H_RES-H_STA or V_RES-V_STA exceeds 32767 as unsupported; no detection is required.

Reset
REQ-032 SHALL, while i_rst_n = 0 at a rising edge, force o_x = H_STA, o_y = V_STA, o_de = 0, o_frame = 0, o_line = 0, o_hsync = ~H_POL and o_vsync = ~V_POL.
REQ-033 SHALL present position (H_STA, V_STA) with o_frame = 1 and o_line = 1 at the first rising edge with i_rst_n = 1 (base build).
REQ-034 SHALL, when reset is asserted mid-frame, abandon the frame at once, with no partial-line completion, and restart per REQ-033.

Configuration
REQ-035 SHALL, when macro DISPLAY_TIMING_OUT_REG_EN is defined, add one extra output register stage on all outputs, so the first position (REQ-033) appears at the second edge after release; reset values are unchanged and all outputs stay mutually aligned.
REQ-036 SHALL, when DISPLAY_TIMING_OUT_REG_EN is undefined, have the base latency of REQ-033 and no extra stage.

Verification
REQ-037 SHALL cover: release reset with defaults -> first edge shows o_x=-160, o_y=-45, o_frame=1, o_line=1, o_de=0, o_hsync=1, o_vsync=1.
REQ-038 SHALL cover: run one full frame -> exactly 420000 clocks between o_frame pulses, 525 o_line pulses per frame, 307200 o_de-high clocks.
REQ-039 SHALL cover: sample one line -> o_hsync low for exactly 96 clocks starting at o_x=-144; o_de rises at o_x=0 (only when o_y>=0) and falls after o_x=639.
REQ-040 SHALL cover: frame wrap -> (o_x=639, o_y=479) is followed by (o_x=-160, o_y=-45) with o_frame=1; o_vsync low on lines y=-35 and y=-34 only (1600 clocks).
REQ-041 SHALL cover: assert i_rst_n=0 at (o_x=100, o_y=200) for 3 clocks -> reset values per REQ-032, then a restart per REQ-033.
REQ-042 SHALL cover: build with DISPLAY_TIMING_OUT_REG_EN defined -> the first o_frame pulse arrives one clock later than in the base build, and all other checks hold with the same one-clock shift.
